// File: rtl/activation_arbiter.sv
// activation_arbiter: round-robin sharing of one bias/activation unit.
// Sequences each granted request through bias-load and execute phases.
module activation_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_value,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_bias,
    input  logic [NUM_REQ*2-1:0]           req_func,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_BITS-1:0]           rsp_data,
    output logic                           busy,
    output logic                           ba_enable,
    output logic [2:0]                     ba_core_state,
    output logic                           ba_activation_enable,
    output logic [1:0]                     ba_activation_func,
    output logic [DATA_BITS-1:0]           ba_unbiased_activation,
    output logic [DATA_BITS-1:0]           ba_bias,
    input  logic [DATA_BITS-1:0]           ba_activation_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         win_idx;
    logic                  win_found;
    logic [DATA_BITS-1:0]  win_value;
    logic [DATA_BITS-1:0]  win_bias;
    logic [1:0]            win_func;
    logic                  xfer;
    logic [IW-1:0]         op_idx;
    logic [DATA_BITS-1:0]  op_value;
    logic [DATA_BITS-1:0]  op_bias;
    logic [1:0]            op_func;

    // Find the first valid requester at or after rr_ptr, wrapping.
    always_comb begin : pick
        logic [IW:0]   j;
        logic [IW-1:0] jj;
        win_found = 1'b0;
        win_idx   = '0;
        j         = '0;
        jj        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, rr_ptr} + (IW+1)'(k);
            if (j >= NREQ_W) begin
                j = j - NREQ_W;
            end
            jj = j[IW-1:0];
            if (!win_found && req_valid[jj]) begin
                win_found = 1'b1;
                win_idx   = jj;
            end
        end
    end

    // Select the winner's operand slices.
    always_comb begin
        win_value = '0;
        win_bias  = '0;
        win_func  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == win_idx) begin
                win_value = req_value[k*DATA_BITS +: DATA_BITS];
                win_bias  = req_bias[k*DATA_BITS +: DATA_BITS];
                win_func  = req_func[k*2 +: 2];
            end
        end
    end

    assign xfer      = (state == IDLE) && win_found;
    assign req_ready = xfer ? (NUM_REQ'(1) << win_idx) : '0;
    assign busy      = (state != IDLE);

    assign ba_unbiased_activation = op_value;
    assign ba_bias                = op_bias;
    assign ba_activation_func     = op_func;

    // Next-state and BA control strobes for the sequencing FSM.
    always_comb begin
        state_nxt            = state;
        ba_enable            = 1'b0;
        ba_core_state        = 3'b000;
        ba_activation_enable = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ba_enable     = 1'b1;
                ba_core_state = 3'b011;
                state_nxt     = EXEC;
            end
            EXEC: begin
                ba_enable            = 1'b1;
                ba_core_state        = 3'b101;
                ba_activation_enable = 1'b1;
                state_nxt            = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted operands and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr   <= '0;
            op_idx   <= '0;
            op_value <= '0;
            op_bias  <= '0;
            op_func  <= '0;
        end else if (xfer) begin
            rr_ptr   <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            op_idx   <= win_idx;
            op_value <= win_value;
            op_bias  <= win_bias;
            op_func  <= win_func;
        end
    end

    // Capture the BA result and pulse the owner's response for one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (state == DONE) begin
                rsp_valid <= NUM_REQ'(1) << op_idx;
                rsp_data  <= ba_activation_out;
            end
        end
    end

endmodule

// File: tb/tb_activation_arbiter.sv
// tb_activation_arbiter: scoreboard bench with a behavioural BA unit.
// Random and directed requests are checked against a grant/latency model.
module tb_activation_arbiter;

    localparam int N  = 4;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DB-1:0] req_value;
    logic [N*DB-1:0] req_bias;
    logic [N*2-1:0]  req_func;
    logic [N-1:0]    rsp_valid;
    logic [DB-1:0]   rsp_data;
    logic            busy;
    logic            ba_enable;
    logic [2:0]      ba_core_state;
    logic            ba_activation_enable;
    logic [1:0]      ba_activation_func;
    logic [DB-1:0]   ba_unbiased_activation;
    logic [DB-1:0]   ba_bias;
    logic [DB-1:0]   ba_activation_out = '0;

    activation_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_value(req_value),
        .req_bias(req_bias),
        .req_func(req_func),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .ba_enable(ba_enable),
        .ba_core_state(ba_core_state),
        .ba_activation_enable(ba_activation_enable),
        .ba_activation_func(ba_activation_func),
        .ba_unbiased_activation(ba_unbiased_activation),
        .ba_bias(ba_bias),
        .ba_activation_out(ba_activation_out)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        pend [N];
    logic [15:0] v_r  [N];
    logic [15:0] b_r  [N];
    logic [1:0]  f_r  [N];
    logic        refill = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        q[$];
    int          glog[$];
    int          ptr = 0;
    int          idle_cycle = 0;
    int          last_grant = -100;
    logic [15:0] m_val = '0;
    logic [15:0] m_bias = '0;
    logic [1:0]  m_func = '0;
    logic [15:0] last_rsp = '0;
    logic [15:0] seen_rsp = '0;
    int          busy_cnt = 0;
    logic [N-1:0] xfer = '0;
    logic [15:0] ba_bias_r = '0;

    // Saturating add then activation, in plain integer arithmetic.
    function automatic logic [15:0] ba_ref(input logic [15:0] v,
                                           input logic [15:0] b,
                                           input logic [1:0] f);
        int s;
        s = int'($signed(v)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        case (f)
            2'd1: if (s < 0) s = 0;
            2'd2: if (s < 0) s = s >>> 7;
            2'd3: begin
                if (s < 0) s = 0;
                if (s > 16384) s = 16384;
            end
            default: ;
        endcase
        return s[15:0];
    endfunction

    // Behavioural BA unit: bias register and registered result.
    always @(posedge clk) begin
        if (ba_enable && ba_core_state == 3'b011)
            ba_bias_r <= ba_bias;
        if (ba_enable && ba_core_state == 3'b101 && ba_activation_enable)
            ba_activation_out <= ba_ref(ba_unbiased_activation,
                                        ba_bias_r, ba_activation_func);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = '0;
        req_value = '0;
        req_bias  = '0;
        req_func  = '0;
        for (int k = 0; k < N; k++) begin
            req_valid[k]           = pend[k];
            req_value[k*DB +: DB]  = v_r[k];
            req_bias[k*DB +: DB]   = b_r[k];
            req_func[k*2 +: 2]     = f_r[k];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare handshake, strobes and responses to the model.
    always @(negedge clk) begin : mon
        int p;
        int w;
        logic [N-1:0] er;
        exp_t e;
        if (!reset) begin
            q.delete();
            ptr = 0;
            idle_cycle = 0;
            last_grant = -100;
            m_val = '0;
            m_bias = '0;
            m_func = '0;
            last_rsp = '0;
            xfer = '0;
        end else begin
            er = '0;
            w = -1;
            if (cyc >= idle_cycle)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(ptr + k) % N])
                        w = (ptr + k) % N;
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("busy", busy, cyc < idle_cycle);
            p = cyc - last_grant;
            chk("ba_enable", ba_enable, p == 1 || p == 2);
            chk("ba_core_state", ba_core_state,
                (p == 1) ? 3 : ((p == 2) ? 5 : 0));
            chk("ba_act_en", ba_activation_enable, p == 2);
            chk("ba_unbiased", ba_unbiased_activation, m_val);
            chk("ba_bias", ba_bias, m_bias);
            chk("ba_func", ba_activation_func, m_func);
            if (busy) busy_cnt++;
            if (q.size() > 0 && q[0].due < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_missing: got none expected idx %0d",
                         q[0].idx);
                void'(q.pop_front());
            end
            if (rsp_valid != 0) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %0h expected 0",
                             rsp_valid);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", rsp_valid, N'(1) << e.idx);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_latency", cyc, e.due);
                    last_rsp = e.data;
                    seen_rsp = rsp_data;
                end
            end else begin
                chk("rsp_data_hold", rsp_data, last_rsp);
            end
            xfer = req_valid & req_ready;
            for (int k = 0; k < N; k++)
                if (xfer[k]) glog.push_back(k);
            if (w >= 0) begin
                q.push_back('{idx: w,
                              data: ba_ref(v_r[w], b_r[w], f_r[w]),
                              due: cyc + 4});
                m_val = v_r[w];
                m_bias = b_r[w];
                m_func = f_r[w];
                ptr = (w + 1) % N;
                idle_cycle = cyc + 4;
                last_grant = cyc;
            end
        end
    end

    task automatic new_rand(input int k);
        pend[k] = 1'b1;
        v_r[k] = 16'($urandom);
        b_r[k] = 16'($urandom);
        f_r[k] = 2'($urandom_range(0, 3));
    endtask

    task automatic issue(input int k, input logic [15:0] v,
                         input logic [15:0] b, input logic [1:0] f);
        pend[k] = 1'b1;
        v_r[k] = v;
        b_r[k] = b;
        f_r[k] = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (xfer[k]) pend[k] = 1'b0;
            if (refill && !pend[k]) new_rand(k);
        end
    endtask

    function automatic bit any_pend();
        for (int k = 0; k < N; k++)
            if (pend[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((any_pend() || q.size() > 0) && n < 300);
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: got timeout expected idle");
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        int n;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            v_r[k] = '0;
            b_r[k] = '0;
            f_r[k] = '0;
        end
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        chk("reset_rsp_data", rsp_data, 16'h0000);

        glog.delete();
        busy_cnt = 0;
        issue(2, 16'h2000, 16'h1000, 2'b01);
        wait_idle();
        chk("relu_data", seen_rsp, 16'h3000);
        chk("relu_busy_cycles", busy_cnt, 3);
        chk("relu_grant", glog.size() > 0 ? glog[0] : -1, 2);

        issue(0, 16'h7000, 16'h7000, 2'b00);
        wait_idle();
        chk("saturate", seen_rsp, 16'h7FFF);
        issue(0, 16'hC000, 16'h0000, 2'b10);
        wait_idle();
        chk("leaky", seen_rsp, 16'hFF80);

        do_reset();
        glog.delete();
        refill = 1'b1;
        for (int k = 0; k < N; k++) new_rand(k);
        n = 0;
        while (glog.size() < 5 && n < 100) begin
            step();
            n++;
        end
        refill = 1'b0;
        wait_idle();
        for (int k = 0; k < 5; k++)
            chk("rr_order", glog.size() > k ? glog[k] : -1, k % N);

        glog.delete();
        issue(3, 16'h0100, 16'h0200, 2'b00);
        wait_idle();
        issue(1, 16'h0300, 16'h0400, 2'b01);
        issue(3, 16'h0500, 16'hF000, 2'b11);
        wait_idle();
        chk("wrap_g1", glog.size() > 1 ? glog[1] : -1, 1);
        chk("wrap_g2", glog.size() > 2 ? glog[2] : -1, 3);

        glog.delete();
        issue(1, 16'h1234, 16'h0111, 2'b01);
        n = 0;
        do begin
            step();
            n++;
        end while (cyc != last_grant + 2 && n < 20);
        reset = 1'b0;
        step();
        reset = 1'b1;
        issue(3, 16'h0A00, 16'h0050, 2'b00);
        issue(0, 16'h8000, 16'h8000, 2'b00);
        wait_idle();
        chk("post_reset_g0", glog.size() > 1 ? glog[1] : -1, 0);
        chk("post_reset_g1", glog.size() > 2 ? glog[2] : -1, 3);
        chk("post_reset_data", seen_rsp, 16'h0A50);

        glog.delete();
        issue(1, 16'h0F00, 16'h00F0, 2'b10);
        issue(2, 16'hF000, 16'h0100, 2'b01);
        wait_idle();
        chk("b2b_last", seen_rsp, 16'h0000);

        for (int c = 0; c < 600; c++) begin
            step();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 199) == 0) reset = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 9) < 3) new_rand(k);
                else if (pend[k] && $urandom_range(0, 99) < 3)
                    pend[k] = 1'b0;
            end
        end
        reset = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
